// File: rtl/dmem_unloader.sv
`default_nettype none
// ============================================================================
// Module   : dmem_unloader
// Brief    : After core END, walks a contiguous block of data memory through
//            the dmem_mux read leg and streams each word out on a
//            valid/ready interface toward the host/display logic.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_unloader #(
   parameter int         ADDR_W   = 16,
   parameter int         DATA_W   = 16,
   parameter int         READ_LAT = 1,
   parameter logic [1:0] MUX_SEL  = 2'd2
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic [1:0]        mux_sel,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   // Latency counter only needs to hold values 1..READ_LAT
   localparam int c_LAT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_remaining;
   logic [c_LAT_W-1:0]  r_lat_cnt;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_read;
   logic [1:0]          r_mux_sel;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_valid;
   logic                r_busy;
   logic                r_done;

   logic [ADDR_W-1:0]   w_addr_next;

   // Next sequential address; natural modulo-2^ADDR_W wrap at the top
   assign w_addr_next = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Transfer sequencer: every output is a register updated with the state
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_lat_cnt   <= '0;
         r_mem_addr  <= '0;
         r_mem_read  <= 1'b0;
         r_mux_sel   <= 2'd0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            // Cancel wins over everything, including a pending handshake
            r_state     <= S_IDLE;
            r_mem_read  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_mux_sel   <= 2'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     if (count != 16'd0) begin
                        r_addr      <= base_addr;
                        r_remaining <= count;
                        r_mem_addr  <= base_addr;
                        r_mem_read  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mux_sel   <= MUX_SEL;
                        r_state     <= S_ISSUE;
                     end else begin
                        // Empty transfer completes without touching memory
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end
               end
               S_ISSUE: begin
                  r_mem_read <= 1'b0;
                  r_lat_cnt  <= c_LAT_W'(READ_LAT);
                  r_state    <= S_WAIT;
               end
               S_WAIT: begin
                  if (r_lat_cnt == c_LAT_W'(1)) begin
                     r_out_data  <= mem_data_in;
                     r_out_valid <= 1'b1;
                     r_state     <= S_HOLD;
                  end else begin
                     r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
                  end
               end
               S_HOLD: begin
                  if (out_ready) begin
                     r_out_valid <= 1'b0;
                     r_addr      <= w_addr_next;
                     r_remaining <= r_remaining - 16'd1;
                     if (r_remaining == 16'd1) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_mux_sel <= 2'd0;
                        r_state   <= S_DONE;
                     end else begin
                        r_mem_addr <= w_addr_next;
                        r_mem_read <= 1'b1;
                        r_state    <= S_ISSUE;
                     end
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state     <= S_IDLE;
                  r_mem_read  <= 1'b0;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_mux_sel   <= 2'd0;
               end
            endcase
         end
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_read  = r_mem_read;
   assign mux_sel   = r_mux_sel;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_unloader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_unloader
// Brief    : Self-checking bench for dmem_unloader against a transaction-level
//            model (expected address/data queues derived from base/count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_unloader;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] count = '0;
   logic [15:0] mem_addr;
   logic        mem_read;
   logic [1:0]  mux_sel;
   logic [15:0] mem_data_in = '0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        done;

   dmem_unloader #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .READ_LAT (1),
      .MUX_SEL  (2'd2)
   ) dut (
      .clk         (clk),
      .RESET       (RESET),
      .start       (start),
      .abort       (abort),
      .base_addr   (base_addr),
      .count       (count),
      .mem_addr    (mem_addr),
      .mem_read    (mem_read),
      .mux_sel     (mux_sel),
      .mem_data_in (mem_data_in),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:65535];
   logic [15:0] exp_addr[$];
   logic [15:0] exp_data[$];
   logic [15:0] rd_log[$];
   logic [15:0] hs_log[$];
   int          vrise[$];
   int          total = 0;
   int          bad = 0;
   int          n_reads = 0;
   int          n_done = 0;
   int          cyc = 0;
   int          rmode = 0;   // 0 manual, 1 ready high, 2 random ready

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Cycle counter and synchronous read memory with one cycle of latency
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (mem_read) mem_data_in <= mem[mem_addr];
   end

   // Per-cycle comparison against the expected transaction queues
   initial begin : compare
      logic        prev_stall;
      logic        prev_hs;
      logic        prev_valid;
      logic [15:0] prev_data;
      prev_stall = 1'b0;
      prev_hs    = 1'b0;
      prev_valid = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!RESET) begin
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
            prev_valid = 1'b0;
         end else begin
            check("mux_sel_vs_busy", mux_sel, busy ? 2 : 0);
            if (mem_read) begin
               n_reads++;
               rd_log.push_back(mem_addr);
               check("read_busy", busy, 1);
               if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
               else check("mem_addr", mem_addr, exp_addr.pop_front());
            end
            if (prev_stall) begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, prev_data);
            end
            if (prev_hs) check("valid_drop", out_valid, 0);
            if (out_valid && !prev_valid) vrise.push_back(cyc);
            if (out_valid && out_ready && !abort) begin
               hs_log.push_back(out_data);
               if (exp_data.size() == 0) check("unexpected_word", 1, 0);
               else check("out_data", out_data, exp_data.pop_front());
            end
            if (done) begin
               n_done++;
               check("done_not_busy", busy, 0);
               check("done_words_left", exp_data.size(), 0);
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_hs    = out_valid && out_ready && !abort;
            prev_valid = out_valid;
            prev_data  = out_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rmode == 1) out_ready = 1'b1;
      else if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push_xfer(input logic [15:0] b, input logic [15:0] c);
      logic [15:0] a;
      for (int k = 0; k < int'(c); k++) begin
         a = b + 16'(k);
         exp_addr.push_back(a);
         exp_data.push_back(mem[a]);
      end
   endtask

   // Launch a transfer from IDLE and wait for its done pulse; optional stray start
   task automatic run_xfer(input logic [15:0] b, input logic [15:0] c, input int poke);
      int  d0;
      bit  seen;
      d0 = n_done;
      seen = 1'b0;
      base_addr = b;
      count = c;
      start = 1'b1;
      push_xfer(b, c);
      tick();
      start = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (n_done != d0) begin
            seen = 1'b1;
            break;
         end
         if (i == poke) begin
            start = 1'b1;
            base_addr = ~b;
            count = 16'd7;
         end
         tick();
         start = 1'b0;
      end
      if (!seen) check("xfer_timeout", 0, 1);
      check("done_once", n_done - d0, 1);
   endtask

   initial begin : stimulus
      int          h0;
      int          r0;
      int          d0;
      int          cs;
      int          i0;
      logic [15:0] b;
      logic [15:0] c;

      for (int k = 0; k < 65536; k++) mem[k] = 16'($urandom);
      mem[16'h0010] = 16'hAAAA;
      mem[16'h0011] = 16'h5555;
      mem[16'h0012] = 16'h1234;

      // Reset state
      #1 RESET = 1'b0;
      #1;
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mux_sel", mux_sel, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      tick();
      tick();
      RESET = 1'b1;
      tick();

      // Basic transfer with ready held high, timing and literal data
      rmode = 1;
      tick();
      vrise.delete();
      h0 = hs_log.size();
      r0 = n_reads;
      cs = cyc;
      run_xfer(16'h0010, 16'd3, -1);
      check("basic_reads", n_reads - r0, 3);
      check("basic_w0", hs_log[h0], 16'hAAAA);
      check("basic_w1", hs_log[h0 + 1], 16'h5555);
      check("basic_w2", hs_log[h0 + 2], 16'h1234);
      check("first_valid_lat", vrise[0] - cs, 3);
      check("word_spacing_1", vrise[1] - vrise[0], 3);
      check("word_spacing_2", vrise[2] - vrise[1], 3);
      tick();

      // Backpressure on word 2 for five cycles
      rmode = 0;
      out_ready = 1'b1;
      h0 = hs_log.size();
      r0 = n_reads;
      d0 = n_done;
      base_addr = 16'h0010;
      count = 16'd3;
      start = 1'b1;
      push_xfer(16'h0010, 16'd3);
      tick();
      start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid && hs_log.size() == h0 + 1) break;
         tick();
      end
      check("bp_reached_word2", out_valid, 1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("bp_data_held", out_data, 16'h5555);
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (n_done != d0) break;
         tick();
      end
      check("bp_done", n_done - d0, 1);
      check("bp_reads", n_reads - r0, 3);
      check("bp_w1", hs_log[h0 + 1], 16'h5555);
      check("bp_w2", hs_log[h0 + 2], 16'h1234);
      tick();

      // Address wrap
      rmode = 1;
      i0 = rd_log.size();
      run_xfer(16'hFFFF, 16'd2, -1);
      check("wrap_a0", rd_log[i0], 16'hFFFF);
      check("wrap_a1", rd_log[i0 + 1], 16'h0000);
      tick();

      // Zero-length transfer
      d0 = n_done;
      r0 = n_reads;
      base_addr = 16'h0500;
      count = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      tick();
      check("zero_done_pulse", done, 0);
      check("zero_no_read", n_reads - r0, 0);
      check("zero_done_count", n_done - d0, 1);
      tick();

      // Stray start mid-transfer is ignored
      r0 = n_reads;
      run_xfer(16'h0040, 16'd3, 4);
      check("stray_reads", n_reads - r0, 3);
      tick();

      // Abort during WAIT of word 2 of a 4-word transfer
      d0 = n_done;
      r0 = n_reads;
      base_addr = 16'h0100;
      count = 16'd4;
      start = 1'b1;
      push_xfer(16'h0100, 16'd4);
      tick();
      start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (n_reads == r0 + 2) break;
         tick();
      end
      abort = 1'b1;
      exp_addr.delete();
      exp_data.delete();
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", out_valid, 0);
      check("abort_read", mem_read, 0);
      check("abort_mux", mux_sel, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_valid_low", out_valid, 0);
      end
      check("abort_no_done", n_done - d0, 0);
      check("abort_reads", n_reads - r0, 2);
      i0 = rd_log.size();
      run_xfer(16'h0300, 16'd2, -1);
      check("post_abort_base", rd_log[i0], 16'h0300);
      tick();

      // Randomized transfers with random backpressure
      rmode = 2;
      for (int t = 0; t < 10; t++) begin
         b = 16'($urandom);
         if (t % 4 == 0) b = 16'hFFFD;
         c = 16'($urandom_range(1, 5));
         run_xfer(b, c, (t % 3 == 0) ? int'($urandom_range(1, 8)) : -1);
         tick();
      end

      // Asynchronous reset while holding a word
      rmode = 0;
      out_ready = 1'b0;
      d0 = n_done;
      base_addr = 16'h0010;
      count = 16'd3;
      start = 1'b1;
      push_xfer(16'h0010, 16'd3);
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         tick();
      end
      check("rh_valid_before", out_valid, 1);
      @(negedge clk);
      #1 RESET = 1'b0;
      #1;
      check("rh_valid", out_valid, 0);
      check("rh_mem_addr", mem_addr, 0);
      check("rh_out_data", out_data, 0);
      check("rh_busy", busy, 0);
      check("rh_mux", mux_sel, 0);
      check("rh_read", mem_read, 0);
      check("rh_done", done, 0);
      exp_addr.delete();
      exp_data.delete();
      tick();
      tick();
      RESET = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rh_idle_valid", out_valid, 0);
         check("rh_idle_busy", busy, 0);
      end
      check("rh_no_done", n_done - d0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/dmem_unloader.md
Name: dmem_unloader

Overview:
- Read-side counterpart to the testbench/host data-memory load path (current_addr / write_from_tb / mem_data).
- After the core raises END, walks a contiguous block of data memory (e.g. the result matrix). Issues reads through the address mux and streams each word out on a valid/ready interface to the host/display logic.
- Sits in top beside data_memory and drives the d_read address leg of dmem_mux plus its select.

Parameters:
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data-memory word width
- READ_LAT, 1, cycles from the mem_read-asserted cycle to the cycle in which mem_data_in is valid (≥1)
- MUX_SEL, 2'd2, value driven on mux_sel while busy to route mem_addr to data memory

Ports:
- clk  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request, typically core END; sampled only in IDLE
- abort  in  1  cancel transfer; returns to IDLE
- base_addr  in  ADDR_W  first address, latched on accepted start
- count  in  16  number of words, latched on accepted start
- mem_addr  out  ADDR_W  read address to dmem_mux d_read leg
- mem_read  out  1  read strobe to data_memory
- mux_sel  out  2  dmem_mux select; MUX_SEL while busy, 2'd0 otherwise
- mem_data_in  in  DATA_W  data_memory data_out
- out_data  out  DATA_W  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  one-cycle pulse at end of a completed transfer

Behaviour:
- Reset is asynchronous and active-low. While RESET=0: state=IDLE; mem_addr, out_data, and the internal addr/remaining registers = 0; mem_read, out_valid, busy, done = 0; mux_sel = 2'd0.
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE; all registered.
- IDLE:
  - start=1 with count≠0: latch addr=base_addr, remaining=count; next state ISSUE.
  - start=1 with count=0: next state DONE; no memory access.
- ISSUE, one cycle: mem_read=1, mem_addr=addr; next state WAIT; latency counter loaded to READ_LAT.
- WAIT, READ_LAT cycles: mem_read=0, mem_addr held. On the last WAIT edge, mem_data_in is captured into out_data; next state HOLD.
- HOLD:
  - out_valid=1; out_data stable until handshake.
  - On out_valid & out_ready: addr=addr+1 (wraps 16'hFFFF→16'h0000) and remaining=remaining-1.
  - Then next state is DONE if remaining was 1, else ISSUE.
  - out_valid falls the cycle after the handshake.
- DONE, one cycle: done=1, busy=0; next state IDLE.
- mem_addr holds the last driven address outside ISSUE/WAIT; it is 0 only after reset.
- start is ignored in every state except IDLE, including DONE.
- abort=1 in any non-IDLE state: next state IDLE; out_valid and mem_read drop the next cycle; no done pulse; captured data is discarded. abort in IDLE has no effect. abort has priority over a simultaneous handshake.
- Throughput: 2+READ_LAT cycles per word with out_ready held high. First out_valid comes 2+READ_LAT cycles after the start edge.
- busy = state ∈ {ISSUE, WAIT, HOLD}; mux_sel follows busy.

Test Plan:
1. Reset mid-HOLD: RESET=0 while out_valid=1 → all outputs 0 immediately (asynchronously). After release, FSM is in IDLE and ignores stale data.
2. Basic transfer: memory preloaded at 0x0010..0x0012 with 0xAAAA, 0x5555, 0x1234; base_addr=0x0010, count=3, out_ready=1, READ_LAT=1.
   - out_data sequence 0xAAAA, 0x5555, 0x1234.
   - First out_valid 3 cycles after start; subsequent words every 3 cycles.
   - mem_read pulses exactly 3 times; done pulses once.
3. Backpressure: same setup with out_ready=0 for 5 cycles on word 2 → out_data holds 0x5555 with out_valid=1 throughout; no extra mem_read; sequence and done are unchanged.
4. Wrap: base_addr=0xFFFF, count=2 → reads addresses 0xFFFF then 0x0000.
5. count=0 and ignored start:
   - start with count=0 → done one cycle later; mem_read never asserted; busy stays 0.
   - A second start asserted mid-transfer is ignored.
6. Abort: abort in WAIT of word 2 of a 4-word transfer → IDLE next cycle; no done; out_valid stays 0. A fresh start then begins at the new base_addr.
